// File: rtl/aquarium_rgb_driver_if.sv
// Command channel from the mode switcher into the aquarium RGB LED driver.
// The sender drives colour, level and fade mode; the driver answers with cmd_ready.
interface aquarium_rgb_driver_if #(
   parameter int PWM_BITS = 8
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [PWM_BITS-1:0] cmd_red;
   logic [PWM_BITS-1:0] cmd_green;
   logic [PWM_BITS-1:0] cmd_blue;
   logic [PWM_BITS-1:0] cmd_level;
   logic                cmd_fade;

   modport master (
      output cmd_valid, cmd_red, cmd_green, cmd_blue, cmd_level, cmd_fade,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_red, cmd_green, cmd_blue, cmd_level, cmd_fade,
      output cmd_ready
   );
endinterface

// File: rtl/aquarium_rgb_driver.sv
// Aquarium RGB LED driver: scales colour commands by brightness, applies or fades them, and drives 3 PWM pins.
// Optional macro AQUARIUM_RGB_GAMMA_EN maps the current colour through an approximate gamma-2 curve.
module aquarium_rgb_driver #(
   parameter int PWM_BITS = 8,
   parameter int FADE_DIV = 1024
) (
   input  logic                 clock,
   input  logic                 reset_n,
   aquarium_rgb_driver_if.slave cmd,
   output logic                 pwm_red,
   output logic                 pwm_green,
   output logic                 pwm_blue,
   output logic                 busy,
   output logic                 done
);
   localparam int                 W        = PWM_BITS;
   localparam int                 PRE_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
   localparam logic [W-1:0]       PERIOD   = {W{1'b1}};
   localparam logic [W-1:0]       CNT_LAST = PERIOD - 1'b1;
   localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(FADE_DIV - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, FADE = 1'b1} state_t;
   typedef logic [2:0][W-1:0] rgb_t;

   // Level is treated as (level + 1) / 2^W so that full level passes the colour unchanged.
   function automatic logic [W-1:0] scale(input logic [W-1:0] c, input logic [W-1:0] lvl);
      logic [2*W-1:0] prod;
      prod = {{W{1'b0}}, c} * ({{W{1'b0}}, lvl} + 1'b1);
      return prod[2*W-1:W];
   endfunction

   function automatic logic [W-1:0] to_duty(input logic [W-1:0] c);
`ifdef AQUARIUM_RGB_GAMMA_EN
      logic [2*W-1:0] sq;
      sq = {{W{1'b0}}, c} * {{W{1'b0}}, c} + {{W{1'b0}}, PERIOD};
      return sq[2*W-1:W];
`else
      return c;
`endif
   endfunction

   state_t           state_q, state_d;
   rgb_t             cur_q, cur_d, tgt_q, tgt_d, duty_q, duty_d;
   rgb_t             cmd_rgb, scaled, stepped;
   logic [W-1:0]     cnt_q, cnt_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             done_q, done_d;
   logic [2:0]       pwm_q, pwm_d;
   logic             accept;

   assign cmd_rgb       = {cmd.cmd_blue, cmd.cmd_green, cmd.cmd_red};
   assign accept        = cmd.cmd_valid && (state_q == IDLE);
   assign cmd.cmd_ready = (state_q == IDLE);
   assign busy          = (state_q == FADE);
   assign done          = done_q;
   assign pwm_red       = pwm_q[0];
   assign pwm_green     = pwm_q[1];
   assign pwm_blue      = pwm_q[2];

   always_comb begin
      scaled  = '0;
      stepped = cur_q;
      for (int i = 0; i < 3; i++) begin
         scaled[i] = scale(cmd_rgb[i], cmd.cmd_level);
         if (cur_q[i] < tgt_q[i]) begin
            stepped[i] = cur_q[i] + 1'b1;
         end else if (cur_q[i] > tgt_q[i]) begin
            stepped[i] = cur_q[i] - 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      tgt_d   = tgt_q;
      pre_d   = pre_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               tgt_d = scaled;
               if (!cmd.cmd_fade || (scaled == cur_q)) begin
                  cur_d  = scaled;
                  done_d = 1'b1;
               end else begin
                  state_d = FADE;
                  pre_d   = '0;
               end
            end
         end
         FADE: begin
            if (pre_q == PRE_LAST) begin
               pre_d = '0;
               cur_d = stepped;
               if (stepped == tgt_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               pre_d = pre_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Duty shadows reload only on the last count so a new colour never cuts a period short.
   always_comb begin
      cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      duty_d = duty_q;
      pwm_d  = '0;
      for (int i = 0; i < 3; i++) begin
         if (cnt_q == CNT_LAST) begin
            duty_d[i] = to_duty(cur_q[i]);
         end
         pwm_d[i] = (cnt_q < duty_q[i]);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cur_q   <= '0;
         tgt_q   <= '0;
         duty_q  <= '0;
         cnt_q   <= '0;
         pre_q   <= '0;
         done_q  <= 1'b0;
         pwm_q   <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         tgt_q   <= tgt_d;
         duty_q  <= duty_d;
         cnt_q   <= cnt_d;
         pre_q   <= pre_d;
         done_q  <= done_d;
         pwm_q   <= pwm_d;
      end
   end
endmodule
